decoder_3to8_stream: RTL and testbench
======================================

# decoder_3to8_stream

Streaming 3-to-8 decoder: accepts `{en, idx}` tokens over a valid/ready handshake, buffers them in a small FIFO, and presents each as an 8-bit one-hot line vector to a downstream consumer. It is the decode-side counterpart of the 8-to-3 priority encoder and expands encoded request indices back into per-line strobes. It also keeps one saturating hit counter per output line for debug readout.

## Interface
- `DEPTH`, default 2: FIFO entries; power of two, minimum 2.
- `CNT_W`, default 8: width of each per-line hit counter.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `in_valid`  in  1  upstream token valid.
- `in_ready`  out  1  block can accept a token this cycle.
- `in_idx`  in  3  encoded line index 0..7.
- `in_en`  in  1  1 = real request; 0 = null token, decodes to all-zero.
- `out_valid`  out  1  head token presented on `out_y`.
- `out_ready`  in  1  downstream accepts the head token.
- `out_y`  out  8  decoded vector: `1 << idx` if en, else 8'h00.
- `cnt_sel`  in  3  selects the line counter shown on `cnt_val`.
- `cnt_clr`  in  1  clears all hit counters.
- `cnt_val`  out  CNT_W  hit count for line `cnt_sel`.

## Operation
- Push: `in_valid && in_ready` at an edge writes `{in_en, in_idx}` at the write pointer.
- Pop: `out_valid && out_ready` at an edge retires the head entry.
- `in_ready = !full`. There is no bypass when full, even if a pop occurs in the same cycle, so there is no combinational path from `out_ready` to `in_ready`.
- `out_valid = !empty`. `out_y` decodes the registered head entry. `out_y` is 8'h00 whenever empty.
- Simultaneous push and pop (not full, not empty): occupancy is unchanged and both pointers advance.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Full/empty are tracked with an occupancy count of width log2(DEPTH)+1.
- Counters: on a pop with en=1, `cnt[idx]` increments and saturates at 2^CNT_W−1. Null tokens (en=0) never count.
- `cnt_clr` zeroes all counters at the edge. If a counted pop occurs in the same cycle, the clear wins and the result is 0.
- `cnt_val = cnt[cnt_sel]` is a combinational read of the registered counters.
- Reset (`rst_n`=0 at an edge):
  - Pointers and occupancy go to 0 and all counters to 0.
  - Outputs after that edge: `out_valid`=0, `out_y`=8'h00, `in_ready`=1, `cnt_val`=0.
  - Reset mid-stream discards all buffered tokens. Handshakes are ignored while `rst_n`=0.

## Timing
- Latency: a token pushed at edge N is visible on `out_valid`/`out_y` in the cycle after edge N, i.e. one cycle.
- Throughput: one token per cycle with DEPTH≥2 and `out_ready` held high.
- Hold rule: while `out_valid && !out_ready`, `out_y` is stable.
- Upstream must hold `in_idx`/`in_en` stable while `in_valid && !in_ready`. The block does not check this.
- Counter update is visible on `cnt_val` the cycle after the pop edge.
- `in_ready` deasserts the cycle after the push that fills the FIFO. It reasserts the cycle after the next pop.

## Structure
- Package `decoder_pkg`:
  - Constants `IDX_W`=3 and `LINES`=8.
  - Typedef `dec_tok_t` as packed `{logic en; logic [IDX_W-1:0] idx;}`.
  - Function `onehot_dec(dec_tok_t) -> logic [LINES-1:0]`.
- One sub-module, `sync_fifo`: parameterised width and depth, synchronous active-low reset, push/pop/full/empty. The top level adds decode and the counter array.

## Test plan
- Reset then stream: push idx 0..7 with en=1 and `out_ready`=1.
  - Required: `out_y` = 01,02,04,…,80 on consecutive cycles, each one cycle after its push.
  - Required: afterwards each `cnt_val` reads 1.
- Null token: push en=0, idx=5.
  - Required: `out_valid`=1 with `out_y`=8'h00.
  - Required: `cnt[5]` stays unchanged.
- Backpressure: hold `out_ready`=0 and push 3 tokens (idx 3,6,1).
  - Required: `in_ready` drops after 2 tokens with DEPTH=2, and `out_y` holds 8'h08.
  - Required: on release, the outputs are 08 then 40, followed by the third token (02) once accepted.
- Saturation and clear:
  - 300 pops of idx 2 with CNT_W=8: `cnt_val` = 255 for `cnt_sel`=2.
  - `cnt_clr` asserted on the same cycle as an idx-2 pop: the counter reads 0.
- Reset mid-operation: FIFO full, assert `rst_n`=0 for one edge.
  - Required: `out_valid`=0, `in_ready`=1, `out_y`=8'h00, and all counters 0.
  - Required: the next pushed token is the first one output.

Source files
------------

// File: rtl/decoder_3to8_stream_pkg.sv
//------------------------------------------------------------------------------
// decoder_pkg
// Purpose : Shared types and helpers for the streaming 3-to-8 decoder.
//           Defines the token carried through the FIFO and the one-hot
//           expansion used on the output side.
// Contents: IDX_W, LINES, TOK_W constants; dec_tok_t token type;
//           onehot_dec() token-to-line-vector function.
//------------------------------------------------------------------------------
package decoder_pkg;

   localparam int IDX_W = 3;
   localparam int LINES = 8;

   // A token is the enable flag plus the encoded line index. The enable sits
   // in the MSB so the packed layout matches {en, idx} on the upstream side.
   typedef struct packed {
      logic             en;
      logic [IDX_W-1:0] idx;
   } dec_tok_t;

   localparam int TOK_W = $bits(dec_tok_t);

   // Expand a token into its line vector. A null token (en=0) yields all
   // zeros, so downstream sees no strobe for it even though it is presented.
   function automatic logic [LINES-1:0] onehot_dec(dec_tok_t tok);
      logic [LINES-1:0] lineVec;
      lineVec = '0;
      if (tok.en) begin
         lineVec[tok.idx] = 1'b1;
      end
      return lineVec;
   endfunction

endpackage

// File: rtl/decoder_3to8_stream_if.sv
//------------------------------------------------------------------------------
// decoder_3to8_stream_if
// Purpose : Bundles the upstream token handshake, the downstream line-vector
//           handshake and the debug counter readout of the streaming decoder.
// Signals : in_valid/in_ready/in_idx/in_en   upstream token channel
//           out_valid/out_ready/out_y        downstream decoded channel
//           cnt_sel/cnt_clr/cnt_val          per-line hit counter readout
// Modports: slave  - the decoder block itself
//           master - the environment driving tokens and consuming lines
//------------------------------------------------------------------------------
interface decoder_3to8_stream_if #(
   parameter int CNT_W = 8
);
   import decoder_pkg::*;

   logic             in_valid;
   logic             in_ready;
   logic [IDX_W-1:0] in_idx;
   logic             in_en;
   logic             out_valid;
   logic             out_ready;
   logic [LINES-1:0] out_y;
   logic [IDX_W-1:0] cnt_sel;
   logic             cnt_clr;
   logic [CNT_W-1:0] cnt_val;

   modport slave (
      input  in_valid, in_idx, in_en, out_ready, cnt_sel, cnt_clr,
      output in_ready, out_valid, out_y, cnt_val
   );

   modport master (
      output in_valid, in_idx, in_en, out_ready, cnt_sel, cnt_clr,
      input  in_ready, out_valid, out_y, cnt_val
   );

endinterface

// File: rtl/decoder_3to8_stream_fifo.sv
//------------------------------------------------------------------------------
// sync_fifo
// Purpose : Small synchronous FIFO with registered storage and an occupancy
//           counter. No bypass: a write into a full FIFO is refused even when
//           a read happens in the same cycle, which keeps the read side free
//           of any combinational path to o_full.
// Ports   : clk, rst_n        clock, synchronous active-low reset
//           i_push, i_wrData  write request and data
//           i_pop             read request (retires the head entry)
//           o_rdData          head entry (valid while !o_empty)
//           o_full, o_empty   occupancy flags
//------------------------------------------------------------------------------
module sync_fifo #(
   parameter int WIDTH = 4,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_wrData,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_rdData,
   output logic             o_full,
   output logic             o_empty
);

   // DEPTH is a power of two, so the pointers wrap naturally at PTR_W bits;
   // the occupancy needs one extra bit to distinguish full from empty.
   localparam int PTR_W = $clog2(DEPTH);
   localparam int OCC_W = PTR_W + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wrPtr;
   logic [PTR_W-1:0] r_rdPtr;
   logic [OCC_W-1:0] r_count;
   logic             w_pushFire;
   logic             w_popFire;

   // Qualify the requests with the flags so an over-eager caller can never
   // corrupt the pointers or the occupancy.
   always_comb begin
      w_pushFire = i_push && !o_full;
      w_popFire  = i_pop && !o_empty;
   end

   // Flags come straight from the registered occupancy.
   always_comb begin
      o_full   = (r_count == OCC_W'(DEPTH));
      o_empty  = (r_count == '0);
      o_rdData = r_mem[r_rdPtr];
   end

   // Storage, pointers and occupancy. A simultaneous push and pop advances
   // both pointers and leaves the occupancy unchanged. Storage is cleared on
   // reset so the head entry never carries stale data after a flush.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else begin
         if (w_pushFire) begin
            r_mem[r_wrPtr] <= i_wrData;
            r_wrPtr        <= r_wrPtr + PTR_W'(1);
         end
         if (w_popFire) begin
            r_rdPtr <= r_rdPtr + PTR_W'(1);
         end
         if (w_pushFire && !w_popFire) begin
            r_count <= r_count + OCC_W'(1);
         end else if (w_popFire && !w_pushFire) begin
            r_count <= r_count - OCC_W'(1);
         end
      end
   end

endmodule

// File: rtl/decoder_3to8_stream.sv
//------------------------------------------------------------------------------
// decoder_3to8_stream
// Purpose : Streaming 3-to-8 decoder. Accepts {en, idx} tokens, buffers them
//           in a small FIFO and presents the head token as a one-hot line
//           vector. Keeps one saturating hit counter per line for debug.
// Params  : DEPTH  FIFO entries (power of two, >= 2)
//           CNT_W  width of each per-line hit counter
// Ports   : clk    single rising-edge clock
//           rst_n  synchronous active-low reset
//           bus    decoder_3to8_stream_if.slave: token in, line vector out,
//                  counter select/clear/readout
//------------------------------------------------------------------------------
module decoder_3to8_stream
   import decoder_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int CNT_W = 8
) (
   input  logic                         clk,
   input  logic                         rst_n,
   decoder_3to8_stream_if.slave         bus
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   dec_tok_t         w_inTok;
   dec_tok_t         w_headTok;
   logic [TOK_W-1:0] w_headRaw;
   logic             w_full;
   logic             w_empty;
   logic             w_popFire;
   logic [CNT_W-1:0] r_hitCnt [LINES];

   // Pack the upstream fields into a token and derive the handshake flags.
   // in_ready depends only on the FIFO state, never on out_ready.
   always_comb begin
      w_inTok.en    = bus.in_en;
      w_inTok.idx   = bus.in_idx;
      w_headTok     = dec_tok_t'(w_headRaw);
      bus.in_ready  = !w_full;
      bus.out_valid = !w_empty;
      w_popFire     = !w_empty && bus.out_ready;
   end

   sync_fifo #(
      .WIDTH (TOK_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_push   (bus.in_valid),
      .i_wrData (w_inTok),
      .i_pop    (bus.out_ready),
      .o_rdData (w_headRaw),
      .o_full   (w_full),
      .o_empty  (w_empty)
   );

   // Decode the registered head entry. Force zero when empty so the line
   // vector never shows a stale token after the last pop.
   always_comb begin
      bus.out_y = '0;
      if (!w_empty) begin
         bus.out_y = onehot_dec(w_headTok);
      end
   end

   // Per-line hit counters. Only real requests count, and only when they are
   // actually retired. The clear takes priority over a same-cycle count so
   // the counter reads zero afterwards.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < LINES; i++) begin
            r_hitCnt[i] <= '0;
         end
      end else if (bus.cnt_clr) begin
         for (int i = 0; i < LINES; i++) begin
            r_hitCnt[i] <= '0;
         end
      end else if (w_popFire && w_headTok.en) begin
         if (r_hitCnt[w_headTok.idx] != CNT_MAX) begin
            r_hitCnt[w_headTok.idx] <= r_hitCnt[w_headTok.idx] + CNT_W'(1);
         end
      end
   end

   // Combinational readout of the selected counter.
   always_comb begin
      bus.cnt_val = r_hitCnt[bus.cnt_sel];
   end

endmodule

// File: tb/tb_decoder_3to8_stream.sv
//------------------------------------------------------------------------------
// tb_decoder_3to8_stream
// Purpose : Directed self-checking bench for decoder_3to8_stream with
//           DEPTH=2, CNT_W=8. Inputs change 1ns after the rising edge and
//           outputs are sampled on the falling edge.
//------------------------------------------------------------------------------
module tb_decoder_3to8_stream;

   logic clk;
   logic rst_n;
   int   compareCount;
   int   failCount;

   decoder_3to8_stream_if #(.CNT_W(8)) bus ();

   decoder_3to8_stream #(
      .DEPTH (2),
      .CNT_W (8)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Free-running 10ns clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive one cycle worth of handshake inputs.
   task automatic applyStimulus(input logic valid, input logic [2:0] idx,
                                input logic en, input logic outReady);
      bus.in_valid  = valid;
      bus.in_idx    = idx;
      bus.in_en     = en;
      bus.out_ready = outReady;
   endtask

   // Count a comparison and report it when observed differs from expected.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      compareCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Move to just after the next rising edge, where inputs are changed.
   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   // Stimulus and checks.
   initial begin
      logic [7:0] expY;
      compareCount = 0;
      failCount    = 0;
      rst_n        = 1'b0;
      bus.cnt_sel  = 3'd0;
      bus.cnt_clr  = 1'b0;
      applyStimulus(1'b0, 3'd0, 1'b0, 1'b0);

      // Reset for two edges.
      nextCycle();
      nextCycle();
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
      checkOutput("rst_out_y", 32'(bus.out_y), 32'h00);
      checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd1);
      checkOutput("rst_cnt_val", 32'(bus.cnt_val), 32'd0);

      // Stream idx 0..7 back to back; each vector appears one cycle later.
      for (int k = 0; k < 8; k++) begin
         nextCycle();
         applyStimulus(1'b1, 3'(k), 1'b1, 1'b1);
         @(negedge clk);
         checkOutput("stream_in_ready", 32'(bus.in_ready), 32'd1);
         if (k == 0) begin
            checkOutput("stream_first_valid", 32'(bus.out_valid), 32'd0);
         end else begin
            expY = 8'h01 << (k - 1);
            checkOutput("stream_out_y", 32'(bus.out_y), 32'(expY));
         end
      end
      nextCycle();
      applyStimulus(1'b0, 3'd0, 1'b0, 1'b1);
      @(negedge clk);
      checkOutput("stream_last_y", 32'(bus.out_y), 32'h80);
      nextCycle();
      @(negedge clk);
      checkOutput("stream_drained", 32'(bus.out_valid), 32'd0);
      for (int s = 0; s < 8; s++) begin
         bus.cnt_sel = 3'(s);
         #1;
         checkOutput("stream_cnt", 32'(bus.cnt_val), 32'd1);
      end

      // Null token: presented but decodes to zero and never counts.
      nextCycle();
      applyStimulus(1'b1, 3'd5, 1'b0, 1'b0);
      nextCycle();
      applyStimulus(1'b0, 3'd0, 1'b0, 1'b1);
      @(negedge clk);
      checkOutput("null_valid", 32'(bus.out_valid), 32'd1);
      checkOutput("null_y", 32'(bus.out_y), 32'h00);
      nextCycle();
      applyStimulus(1'b0, 3'd0, 1'b0, 1'b0);
      bus.cnt_sel = 3'd5;
      @(negedge clk);
      checkOutput("null_cnt5", 32'(bus.cnt_val), 32'd1);

      // Backpressure: 3,6 fill the FIFO, 1 waits until space frees.
      nextCycle();
      applyStimulus(1'b1, 3'd3, 1'b1, 1'b0);
      @(negedge clk);
      checkOutput("bp_ready0", 32'(bus.in_ready), 32'd1);
      nextCycle();
      applyStimulus(1'b1, 3'd6, 1'b1, 1'b0);
      @(negedge clk);
      checkOutput("bp_ready1", 32'(bus.in_ready), 32'd1);
      checkOutput("bp_hold_y1", 32'(bus.out_y), 32'h08);
      nextCycle();
      applyStimulus(1'b1, 3'd1, 1'b1, 1'b0);
      @(negedge clk);
      checkOutput("bp_full", 32'(bus.in_ready), 32'd0);
      checkOutput("bp_hold_y2", 32'(bus.out_y), 32'h08);
      nextCycle();
      applyStimulus(1'b1, 3'd1, 1'b1, 1'b1);
      @(negedge clk);
      checkOutput("bp_full_pop", 32'(bus.in_ready), 32'd0);
      checkOutput("bp_rel_y0", 32'(bus.out_y), 32'h08);
      nextCycle();
      @(negedge clk);
      checkOutput("bp_reready", 32'(bus.in_ready), 32'd1);
      checkOutput("bp_rel_y1", 32'(bus.out_y), 32'h40);
      nextCycle();
      applyStimulus(1'b0, 3'd0, 1'b0, 1'b1);
      @(negedge clk);
      checkOutput("bp_rel_y2", 32'(bus.out_y), 32'h02);
      nextCycle();
      @(negedge clk);
      checkOutput("bp_empty", 32'(bus.out_valid), 32'd0);

      // Saturation: 300 pops of idx 2 on top of the earlier single hit.
      for (int k = 0; k < 300; k++) begin
         nextCycle();
         applyStimulus(1'b1, 3'd2, 1'b1, 1'b1);
      end
      nextCycle();
      applyStimulus(1'b0, 3'd0, 1'b0, 1'b1);
      nextCycle();
      bus.cnt_sel = 3'd2;
      @(negedge clk);
      checkOutput("sat_cnt2", 32'(bus.cnt_val), 32'd255);
      bus.cnt_sel = 3'd3;
      #1;
      checkOutput("sat_cnt3", 32'(bus.cnt_val), 32'd2);

      // Clear coinciding with a counted idx-2 pop: clear wins.
      applyStimulus(1'b1, 3'd2, 1'b1, 1'b0);
      nextCycle();
      applyStimulus(1'b0, 3'd0, 1'b0, 1'b1);
      bus.cnt_clr = 1'b1;
      nextCycle();
      bus.cnt_clr = 1'b0;
      bus.cnt_sel = 3'd2;
      @(negedge clk);
      checkOutput("clr_cnt2", 32'(bus.cnt_val), 32'd0);
      bus.cnt_sel = 3'd3;
      #1;
      checkOutput("clr_cnt3", 32'(bus.cnt_val), 32'd0);

      // One more idx-2 hit so the reset below has something to clear.
      nextCycle();
      applyStimulus(1'b1, 3'd2, 1'b1, 1'b1);
      nextCycle();
      applyStimulus(1'b0, 3'd0, 1'b0, 1'b1);
      nextCycle();
      bus.cnt_sel = 3'd2;
      @(negedge clk);
      checkOutput("post_clr_cnt2", 32'(bus.cnt_val), 32'd1);

      // Fill the FIFO, then reset for one edge with a handshake pending.
      nextCycle();
      applyStimulus(1'b1, 3'd4, 1'b1, 1'b0);
      nextCycle();
      applyStimulus(1'b1, 3'd7, 1'b1, 1'b0);
      nextCycle();
      applyStimulus(1'b1, 3'd0, 1'b1, 1'b1);
      @(negedge clk);
      checkOutput("mid_full", 32'(bus.in_ready), 32'd0);
      rst_n = 1'b0;
      nextCycle();
      rst_n = 1'b1;
      applyStimulus(1'b0, 3'd0, 1'b0, 1'b0);
      @(negedge clk);
      checkOutput("mid_rst_valid", 32'(bus.out_valid), 32'd0);
      checkOutput("mid_rst_ready", 32'(bus.in_ready), 32'd1);
      checkOutput("mid_rst_y", 32'(bus.out_y), 32'h00);
      for (int s = 0; s < 8; s++) begin
         bus.cnt_sel = 3'(s);
         #1;
         checkOutput("mid_rst_cnt", 32'(bus.cnt_val), 32'd0);
      end

      // First token after reset is the first one out.
      nextCycle();
      applyStimulus(1'b1, 3'd5, 1'b1, 1'b0);
      nextCycle();
      applyStimulus(1'b0, 3'd0, 1'b0, 1'b0);
      @(negedge clk);
      checkOutput("post_rst_y", 32'(bus.out_y), 32'h20);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
      $finish;
   end

endmodule
